// File: rtl/button_events_pkg.sv
// Shared types and constants for the push-button event path.
// Optional long-press logic is enabled by defining BTN_LONGPRESS_EN.
package button_events_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } btn_state_e;

  // 10 ms debounce and 1 s hold at the 12 MHz board clock
  localparam int DEB_12MHZ_10MS = 120000;
  localparam int LONG_12MHZ_1S  = 12000000;

  typedef struct packed {
    logic       level;
    logic       press;
    logic       rel;
    logic       long_press;
    logic [7:0] cnt;
  } btn_evt_t;

endpackage

// File: rtl/button_events_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, event pulses, press counter.
// BTN_LONGPRESS_EN adds the hold timer and long_press pulse.
module btn_debounce_ch
  import button_events_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_12MHZ_10MS,
  parameter int LONG_CYCLES = LONG_12MHZ_1S,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pin,
  output btn_evt_t evt
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    st, st_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt, deb_inc;
  logic          lvl_q, press_q, rel_q, long_q;
  logic          lvl_nxt, press_nxt, rel_nxt;
  logic [7:0]    cnt_q;

  // polarity fix is applied after the synchronizer so the flops see the raw pin
  assign s       = sync_q[1] ^ ACTIVE_LOW;
  assign deb_inc = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;

  always_comb begin
    st_nxt    = st;
    deb_nxt   = deb_cnt;
    lvl_nxt   = lvl_q;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (st)
      ST_IDLE: if (s) begin
        st_nxt  = ST_PRESS_DB;
        deb_nxt = '0;
      end
      ST_PRESS_DB: begin
        if (!s) st_nxt = ST_IDLE;
        else if (deb_inc == DEB_LAST) begin
          st_nxt    = ST_HELD;
          lvl_nxt   = 1'b1;
          press_nxt = 1'b1;
        end else deb_nxt = deb_inc;
      end
      ST_HELD: if (!s) begin
        st_nxt  = ST_RELEASE_DB;
        deb_nxt = '0;
      end
      ST_RELEASE_DB: begin
        if (s) st_nxt = ST_HELD;
        else if (deb_inc == DEB_LAST) begin
          st_nxt  = ST_IDLE;
          lvl_nxt = 1'b0;
          rel_nxt = 1'b1;
        end else deb_nxt = deb_inc;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      st      <= ST_IDLE;
      deb_cnt <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pin};
      st      <= st_nxt;
      deb_cnt <= deb_nxt;
      lvl_q   <= lvl_nxt;
      press_q <= press_nxt;
      rel_q   <= rel_nxt;
      if (press_nxt) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;

  // saturating at LONG_CYCLES makes the pulse one-shot until the next accepted press
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (st == ST_PRESS_DB && st_nxt == ST_HELD) hold_cnt <= '0;
      else if (st == ST_HELD || st == ST_RELEASE_DB) begin
        if (hold_cnt != LONG_MAX) hold_cnt <= hold_cnt + 1'b1;
        long_q <= (hold_cnt == LONG_LAST);
      end
    end
  end
`else
  // LONG_CYCLES has no effect in this build
  assign long_q = 1'b0 & (LONG_CYCLES > 0);
`endif

  assign evt = '{level: lvl_q, press: press_q, rel: rel_q, long_press: long_q, cnt: cnt_q};

endmodule

// File: rtl/button_events.sv
// Raw push-button pins to clean per-channel events; one debounce channel per button.
// `release` is a reserved word, so release pulses come out on `rel`. Long-press via BTN_LONGPRESS_EN.
module button_events
  import button_events_pkg::*;
#(
  parameter int NBTN        = 2,
  parameter int DEB_CYCLES  = DEB_12MHZ_10MS,
  parameter int LONG_CYCLES = LONG_12MHZ_1S,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NBTN-1:0]     btn_in,
  output logic [NBTN-1:0]     btn_level,
  output logic [NBTN-1:0]     press,
  output logic [NBTN-1:0]     rel,
  output logic [NBTN-1:0]     long_press,
  output logic [8*NBTN-1:0]   press_cnt
);

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_evt_t evt;

    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .pin(btn_in[i]),
      .evt(evt)
    );

    assign btn_level[i]        = evt.level;
    assign press[i]            = evt.press;
    assign rel[i]              = evt.rel;
    assign long_press[i]       = evt.long_press;
    assign press_cnt[8*i +: 8] = evt.cnt;
  end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: vector table, directed corner sequences, random run against a run-length model.
module tb_button_events;
  localparam int NBTN = 2, DEB = 4, LONG = 20;
`ifdef BTN_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  btn_in = '0;
  logic [1:0]  btn_level, press, rel, long_press;
  logic [15:0] press_cnt;

  always #5 clk = ~clk;

  button_events #(.NBTN(NBTN), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .press(press),
    .rel(rel), .long_press(long_press), .press_cnt(press_cnt)
  );

  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a level flips once the last DEB synchronized samples all disagree with it.
  logic [1:0] m_level, m_press, m_rel, m_long;
  logic [7:0] m_cnt [2];
  int         m_held [2];
  logic       m_smp [2][DEB+2];
  bit         m_flip, m_was;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
      if (rst) begin
        m_level[c] = 1'b0; m_cnt[c] = '0; m_held[c] = 0;
        for (int j = 0; j < DEB+2; j++) m_smp[c][j] = 1'b0;
      end else begin
        for (int j = DEB+1; j > 0; j--) m_smp[c][j] = m_smp[c][j-1];
        m_smp[c][0] = btn_in[c];
        m_was  = m_level[c];
        m_flip = 1'b1;
        for (int j = 2; j < DEB+2; j++) if (m_smp[c][j] == m_was) m_flip = 1'b0;
        if (m_was) begin
          m_held[c]++;
          if (LONG_EN && m_held[c] == LONG) m_long[c] = 1'b1;
        end
        if (m_flip) begin
          m_level[c] = !m_was;
          if (!m_was) begin m_press[c] = 1'b1; m_cnt[c] = m_cnt[c] + 8'd1; m_held[c] = 0; end
          else m_rel[c] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    chk("model level", btn_level, m_level);
    chk("model press", press, m_press);
    chk("model release", rel, m_rel);
    chk("model long_press", long_press, m_long);
    chk("model press_cnt", press_cnt, {m_cnt[1], m_cnt[0]});
  end

  // drive at a negedge, return at the next negedge (one posedge consumed)
  task automatic tick(input logic [1:0] b, input logic r);
    btn_in = b; rst = r;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  btn;
    logic [1:0]  lvl, prs, rls;
    logic [15:0] cnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [1:0] b, input logic [1:0] l, input logic [1:0] p,
                     input logic [1:0] r, input logic [15:0] c);
    vec_t v;
    v.btn = b; v.lvl = l; v.prs = p; v.rls = r; v.cnt = c;
    vq.push_back(v);
  endtask

  int pk, rk, lk, nrel, nlong, nprs;

  initial begin
    // clean press held 10 cycles, release, then a 1,0,1,0 bounce
    for (int i = 0; i < 5; i++) add(2'b01, 2'b00, 2'b00, 2'b00, 16'd0);
    add(2'b01, 2'b01, 2'b01, 2'b00, 16'd1);
    for (int i = 0; i < 4; i++) add(2'b01, 2'b01, 2'b00, 2'b00, 16'd1);
    for (int i = 0; i < 5; i++) add(2'b00, 2'b01, 2'b00, 2'b00, 16'd1);
    add(2'b00, 2'b00, 2'b00, 2'b01, 16'd1);
    for (int i = 0; i < 2; i++) add(2'b00, 2'b00, 2'b00, 2'b00, 16'd1);
    add(2'b01, 2'b00, 2'b00, 2'b00, 16'd1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 16'd1);
    add(2'b01, 2'b00, 2'b00, 2'b00, 16'd1);
    for (int i = 0; i < 7; i++) add(2'b00, 2'b00, 2'b00, 2'b00, 16'd1);

    repeat (3) @(negedge clk);
    chk("reset level", btn_level, 2'b00);
    chk("reset press", press, 2'b00);
    chk("reset release", rel, 2'b00);
    chk("reset long", long_press, 2'b00);
    chk("reset press_cnt", press_cnt, 16'd0);
    mon_en = 1'b1;
    repeat (3) tick(2'b00, 1'b0);

    foreach (vq[i]) begin
      tick(vq[i].btn, 1'b0);
      chk($sformatf("vec%0d level", i), btn_level, vq[i].lvl);
      chk($sformatf("vec%0d press", i), press, vq[i].prs);
      chk($sformatf("vec%0d release", i), rel, vq[i].rls);
      chk($sformatf("vec%0d press_cnt", i), press_cnt, vq[i].cnt);
    end

    // release glitch: 2 low, 2 high, then low; release 5 ticks after the glitch ends
    pk = -1; rk = -1; nrel = 0;
    for (int k = 0; k < 22; k++) begin
      tick((k < 8 || (k >= 10 && k < 12)) ? 2'b01 : 2'b00, 1'b0);
      if (press[0]) pk = k;
      if (rel[0]) begin nrel++; rk = k; end
      if (k == 16) chk("glitch level held", btn_level[0], 1'b1);
    end
    chk("glitch press index", pk, 5);
    chk("glitch release count", nrel, 1);
    chk("glitch release index", rk, 17);

    // 256 presses on channel 1 wrap its counter; channel 0 untouched
    for (int p = 0; p < 256; p++) begin
      repeat (5) tick(2'b10, 1'b0);
      repeat (5) tick(2'b00, 1'b0);
      if (p == 254) chk("ch1 count 255", press_cnt[15:8], 8'd255);
    end
    chk("ch1 count wrap", press_cnt[15:8], 8'd0);
    chk("ch0 count kept", press_cnt[7:0], 8'd2);
    repeat (8) tick(2'b00, 1'b0);

    // long hold of 40 cycles
    pk = -1; lk = -1; nlong = 0;
    for (int k = 0; k < 40; k++) begin
      tick(2'b01, 1'b0);
      if (press[0]) pk = k;
      if (long_press[0]) begin nlong++; lk = k; end
    end
    for (int k = 0; k < 10; k++) begin
      tick(2'b00, 1'b0);
      if (long_press[0]) nlong++;
    end
`ifdef BTN_LONGPRESS_EN
    chk("long pulse count", nlong, 1);
    chk("long after press", lk - pk, LONG);
`else
    chk("long stays low", nlong, 0);
`endif
    chk("ch0 count 3", press_cnt[7:0], 8'd3);

    // reset while held, button still down after reset
    repeat (10) tick(2'b01, 1'b0);
    chk("held before reset", btn_level[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(2'b01, 1'b1);
      chk("rst level", btn_level, 2'b00);
      chk("rst press", press, 2'b00);
      chk("rst release", rel, 2'b00);
      chk("rst press_cnt", press_cnt, 16'd0);
    end
    pk = -1; nrel = 0; nprs = 0;
    for (int k = 0; k < 10; k++) begin
      tick(2'b01, 1'b0);
      if (press[0]) begin pk = k; nprs++; end
      if (rel[0]) nrel++;
    end
    chk("post-rst press index", pk, 5);
    chk("post-rst press count", nprs, 1);
    chk("post-rst no release", nrel, 0);
    chk("post-rst press_cnt", press_cnt[7:0], 8'd1);
    repeat (10) tick(2'b00, 1'b0);

    // random bursts of bouncy runs on both channels, rare resets
    begin
      logic [1:0] pin;
      int run [2];
      pin = 2'b00; run[0] = 1; run[1] = 1;
      for (int k = 0; k < 3000; k++) begin
        for (int c = 0; c < 2; c++) begin
          run[c]--;
          if (run[c] == 0) begin
            pin[c] = ~pin[c];
            run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2))
                                                 : int'($urandom_range(3, 30));
          end
        end
        tick(pin, ($urandom_range(0, 599) == 0));
      end
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
